fe_fetch: RTL and testbench

Instruction fetch front end and the requesting side of the instruction ROM. Holds the PC, drives the ROM's asynchronous read address and captures the returned word the same cycle. Buffers fetched instructions with their PCs in a small in-order queue. Presents them to the backend over a valid/ready handshake and accepts PC redirects from the backend.

---
 rtl/fe_fetch.sv | 120 ++++++++++++
 tb/tb_fe_fetch.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fe_fetch.sv
// fe_fetch: instruction fetch front end.
//   Holds the fetch PC, drives the instruction ROM's asynchronous read port and
//   captures the returned word in the same cycle into a small in-order queue.
//   The queue head goes to the backend over a valid/ready handshake. A redirect
//   from the backend flushes the queue and restarts fetch at the given target.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   rom_addr_o / rom_data_i  ROM read address (the PC) / combinational read data
//   instr_v_o, instr_o, pc_o queue head valid, instruction, word address
//   instr_ready_i            backend takes the head this cycle
//   redirect_v_i/_pc_i       backend redirect request and target PC
module fe_fetch #(
  parameter int unsigned I_CACHE_DEPTH_P = 256,
  parameter int unsigned WORD_SIZE_P     = 16,
  parameter int unsigned QUEUE_DEPTH_P   = 2,
  parameter int unsigned RESET_PC_P      = 0,
  localparam int unsigned ADDR_WIDTH_LP  = $clog2(I_CACHE_DEPTH_P)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic [ADDR_WIDTH_LP-1:0] rom_addr_o,
  input  logic [WORD_SIZE_P-1:0]   rom_data_i,
  output logic                     instr_v_o,
  output logic [WORD_SIZE_P-1:0]   instr_o,
  output logic [ADDR_WIDTH_LP-1:0] pc_o,
  input  logic                     instr_ready_i,
  input  logic                     redirect_v_i,
  input  logic [ADDR_WIDTH_LP-1:0] redirect_pc_i
);

  // A depth-1 queue still needs a 1-bit pointer to index its single entry.
  localparam int unsigned PTR_W = (QUEUE_DEPTH_P > 1) ? $clog2(QUEUE_DEPTH_P) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH_P + 1);

  localparam logic [PTR_W-1:0]         PTR_LAST = PTR_W'(QUEUE_DEPTH_P - 1);
  localparam logic [CNT_W-1:0]         DEPTH_C  = CNT_W'(QUEUE_DEPTH_P);
  localparam logic [ADDR_WIDTH_LP-1:0] PC_LAST  = ADDR_WIDTH_LP'(I_CACHE_DEPTH_P - 1);
  localparam logic [ADDR_WIDTH_LP-1:0] PC_RST   = ADDR_WIDTH_LP'(RESET_PC_P);

  typedef struct packed {
    logic [ADDR_WIDTH_LP-1:0] pc;
    logic [WORD_SIZE_P-1:0]   instr;
  } entry_t;

  entry_t                   q_mem [QUEUE_DEPTH_P];
  logic [ADDR_WIDTH_LP-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     enq, deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Explicit wrap so non-power-of-two ROM depths never address past the end.
  function automatic logic [ADDR_WIDTH_LP-1:0] pc_inc(input logic [ADDR_WIDTH_LP-1:0] p);
    return (p == PC_LAST) ? '0 : p + ADDR_WIDTH_LP'(1);
  endfunction

  assign rom_addr_o = pc_q;
  assign instr_v_o  = (count_q != '0);
  assign instr_o    = q_mem[rd_q].instr;
  assign pc_o       = q_mem[rd_q].pc;

  assign deq = instr_v_o & instr_ready_i;
  // A full queue that drains this cycle frees the slot for the word being fetched.
  assign enq = ~redirect_v_i & ((count_q < DEPTH_C) | deq);

  always_comb begin
    pc_d    = pc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (redirect_v_i) begin
      // A same-cycle dequeue has already completed; everything else is dropped.
      pc_d    = redirect_pc_i;
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        pc_d = pc_inc(pc_q);
        wr_d = ptr_inc(wr_q);
      end
      if (deq) rd_d = ptr_inc(rd_q);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q    <= PC_RST;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i && enq) q_mem[wr_q] <= '{pc: pc_q, instr: rom_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (redirect_v_i)
        assert ({1'b0, redirect_pc_i} < (ADDR_WIDTH_LP+1)'(I_CACHE_DEPTH_P))
          else $error("redirect target out of ROM range");
      assert (count_q <= DEPTH_C) else $error("fetch queue overflow");
      assert ({1'b0, pc_q} < (ADDR_WIDTH_LP+1)'(I_CACHE_DEPTH_P))
        else $error("fetch pc out of ROM range");
    end
  end

endmodule

// File: tb/tb_fe_fetch.sv
module tb_fe_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 256-word ROM.
  logic        reset_i, instr_ready_i, redirect_v_i, instr_v_o;
  logic [7:0]  redirect_pc_i, rom_addr_o, pc_o;
  logic [15:0] rom_data_i, instr_o;
  assign rom_data_i = 16'hA000 + {8'h00, rom_addr_o};

  fe_fetch #(.I_CACHE_DEPTH_P(256), .WORD_SIZE_P(16), .QUEUE_DEPTH_P(2), .RESET_PC_P(0)) dut (
    .clk_i(clk), .reset_i(reset_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .instr_v_o(instr_v_o), .instr_o(instr_o), .pc_o(pc_o), .instr_ready_i(instr_ready_i),
    .redirect_v_i(redirect_v_i), .redirect_pc_i(redirect_pc_i));

  // Wrap instance: 10-word ROM.
  logic        rst10, rdy10, redir10, v10;
  logic [3:0]  redir_pc10, addr10, pc10;
  logic [15:0] data10, instr10;
  assign data10 = 16'hA000 + {12'h000, addr10};

  fe_fetch #(.I_CACHE_DEPTH_P(10), .WORD_SIZE_P(16), .QUEUE_DEPTH_P(2), .RESET_PC_P(0)) dut10 (
    .clk_i(clk), .reset_i(rst10), .rom_addr_o(addr10), .rom_data_i(data10),
    .instr_v_o(v10), .instr_o(instr10), .pc_o(pc10), .instr_ready_i(rdy10),
    .redirect_v_i(redir10), .redirect_pc_i(redir_pc10));

  int errors = 0;
  int checks = 0;
  int expq[$];
  int exp10[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every accepted head is popped against the expected PC.
  always @(negedge clk) begin
    if (!reset_i && instr_v_o && instr_ready_i) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL main_unexpected: got pc %0d with no entry expected", pc_o);
      end else begin
        int e;
        e = expq.pop_front();
        chk("main_pc", 32'(pc_o), 32'(e));
        chk("main_instr", 32'(instr_o), 32'h0000A000 + 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst10) begin
      chk("wrap_addr_lt10", 32'(addr10 < 4'd10), 32'd1);
      if (v10 && rdy10) begin
        if (exp10.size() == 0) begin
          checks++; errors++;
          $display("FAIL wrap_unexpected: got pc %0d with no entry expected", pc10);
        end else begin
          int e;
          e = exp10.pop_front();
          chk("wrap_pc", 32'(pc10), 32'(e));
          chk("wrap_instr", 32'(instr10), 32'h0000A000 + 32'(e));
        end
      end
    end
  end

  initial begin
    reset_i = 1'b1; instr_ready_i = 1'b1; redirect_v_i = 1'b0; redirect_pc_i = 8'd0;
    rst10 = 1'b1; rdy10 = 1'b0; redir10 = 1'b0; redir_pc10 = 4'd0;

    // Reset state and streaming from PC 0.
    tick(); tick();
    chk("rst_valid", 32'(instr_v_o), 32'd0);
    chk("rst_addr", 32'(rom_addr_o), 32'd0);
    for (int k = 0; k < 8; k++) expq.push_back(k);
    reset_i = 1'b0;
    tick();
    chk("lat_first_valid", 32'(instr_v_o), 32'd1);
    chk("lat_first_pc", 32'(pc_o), 32'd0);
    chk("lat_first_instr", 32'(instr_o), 32'h0000A000);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stream_nogap", 32'(instr_v_o), 32'd1);
    end
    tick();
    instr_ready_i = 1'b0;
    chk("stream_drained", 32'(expq.size()), 32'd0);

    // Backpressure: queue fills at 2 entries and the PC stalls at 2.
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_addr", 32'(rom_addr_o), 32'd2);
    chk("stall_valid", 32'(instr_v_o), 32'd1);
    chk("stall_head", 32'(pc_o), 32'd0);
    for (int k = 0; k < 3; k++) expq.push_back(k);
    instr_ready_i = 1'b1;
    tick(); tick(); tick();
    instr_ready_i = 1'b0;

    // Full queue, single-cycle ready pulse: one deq plus one enq.
    tick();
    chk("full_addr", 32'(rom_addr_o), 32'd5);
    expq.push_back(3);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("pulse_addr", 32'(rom_addr_o), 32'd6);
    chk("pulse_head", 32'(pc_o), 32'd4);
    tick();
    chk("pulse_full_hold", 32'(rom_addr_o), 32'd6);
    chk("pulse_drained", 32'(expq.size()), 32'd0);

    // Redirect to 40 while the head is PC 5 and being accepted.
    reset_i = 1'b1; instr_ready_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    for (int k = 0; k < 6; k++) expq.push_back(k);
    for (int i = 0; i < 6; i++) tick();
    chk("redir_head_before", 32'(pc_o), 32'd5);
    redirect_v_i = 1'b1; redirect_pc_i = 8'd40;
    tick();
    redirect_v_i = 1'b0;
    chk("redir_bubble", 32'(instr_v_o), 32'd0);
    for (int k = 40; k < 43; k++) expq.push_back(k);
    tick();
    chk("redir_valid", 32'(instr_v_o), 32'd1);
    chk("redir_pc", 32'(pc_o), 32'd40);
    chk("redir_instr", 32'(instr_o), 32'h0000A028);
    tick(); tick(); tick();
    instr_ready_i = 1'b0;

    // Reset with a full queue and a simultaneous redirect.
    tick(); tick();
    reset_i = 1'b1; redirect_v_i = 1'b1; redirect_pc_i = 8'd77;
    expq.delete();
    tick();
    reset_i = 1'b0; redirect_v_i = 1'b0;
    chk("rst_mid_valid", 32'(instr_v_o), 32'd0);
    chk("rst_mid_addr", 32'(rom_addr_o), 32'd0);
    for (int k = 0; k < 3; k++) expq.push_back(k);
    instr_ready_i = 1'b1;
    tick();
    chk("rst_resume_pc", 32'(pc_o), 32'd0);
    tick(); tick(); tick();
    instr_ready_i = 1'b0;

    // Non-power-of-two ROM: PCs wrap 9 -> 0.
    rdy10 = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) exp10.push_back(k);
    exp10.push_back(0);
    exp10.push_back(1);
    rst10 = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    rdy10 = 1'b0;
    tick(); tick();
    chk("wrap_drained", 32'(exp10.size()), 32'd0);
    chk("main_drained", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
